// File: rtl/mips_div_if.sv
// Handshake and operand bundle between the EX stage and the iterative divider.
interface mips_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start;
    logic               signed_div;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               annul;
    logic               stall_all;
    logic               div_stall;
    logic               ready;
    logic [2*WIDTH-1:0] result;

    modport master (
        output start, signed_div, a, b, annul, stall_all,
        input  div_stall, ready, result
    );

    modport slave (
        input  start, signed_div, a, b, annul, stall_all,
        output div_stall, ready, result
    );
endinterface

// File: rtl/mips_div.sv
// Restoring radix-2 divider for DIV/DIVU in EX: one quotient bit per cycle,
// returns {HI=remainder, LO=quotient} and stalls the front of the pipe while busy.
module mips_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        resetn,
    mips_div_if.slave   bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divState_t;

    divState_t          stateQ;
    divState_t          stateD;

    logic [WIDTH-1:0]   dvdQ;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   dvsQ;
    logic [WIDTH-1:0]   remQ;
    logic [CNT_W-1:0]   countQ;
    logic               negQuoQ;
    logic               negRemQ;
    logic [2*WIDTH-1:0] resultQ;

    logic               launch;
    logic               zeroDiv;
    logic               lastStep;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic [WIDTH:0]     partial;
    logic               fits;
    logic [WIDTH-1:0]   remNext;
    logic [WIDTH-1:0]   quoNext;
    logic [WIDTH-1:0]   quoFinal;
    logic [WIDTH-1:0]   remFinal;

    // Operand capture and one restoring step
    always_comb begin
        launch   = bus.start & ~bus.annul & (stateQ == IDLE);
        zeroDiv  = (bus.b == '0);
        lastStep = (stateQ == BUSY) & (countQ == CNT_W'(WIDTH - 1));

        aMag = (bus.signed_div & bus.a[WIDTH-1]) ? WIDTH'(-bus.a) : bus.a;
        bMag = (bus.signed_div & bus.b[WIDTH-1]) ? WIDTH'(-bus.b) : bus.b;

        partial = {remQ, dvdQ[WIDTH-1]};
        fits    = (partial >= {1'b0, dvsQ});
        // When the step fits, the true difference is below 2^WIDTH, so the low bits suffice
        remNext = fits ? WIDTH'(partial[WIDTH-1:0] - dvsQ) : partial[WIDTH-1:0];
        quoNext = {dvdQ[WIDTH-2:0], fits};

        quoFinal = negQuoQ ? WIDTH'(-quoNext) : quoNext;
        remFinal = negRemQ ? WIDTH'(-remNext) : remNext;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic; annul wins over start and stall_all
    always_comb begin
        stateD = stateQ;
        if (bus.annul) begin
            stateD = IDLE;
        end else begin
            unique case (stateQ)
                IDLE: begin
                    if (bus.start) begin
                        stateD = zeroDiv ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (lastStep) begin
                        stateD = DONE;
                    end
                end
                DONE: begin
                    if (!bus.stall_all) begin
                        stateD = IDLE;
                    end
                end
                default: stateD = IDLE;
            endcase
        end
    end

    // Outputs: div_stall must be combinational so the hazard unit holds F/D in the DIV's first EX cycle
    always_comb begin
        bus.div_stall = 1'b0;
        bus.ready     = 1'b0;
        bus.result    = resultQ;
        if (resetn) begin
            bus.div_stall = (bus.start & (stateQ == IDLE)) | (stateQ == BUSY);
        end
        bus.ready = (stateQ == DONE) & ~bus.annul;
    end

    // Datapath registers; the iteration keeps running through stall_all
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dvdQ    <= '0;
            dvsQ    <= '0;
            remQ    <= '0;
            countQ  <= '0;
            negQuoQ <= 1'b0;
            negRemQ <= 1'b0;
            resultQ <= '0;
        end else if (launch) begin
            if (zeroDiv) begin
                resultQ <= {bus.a, {WIDTH{1'b1}}};
            end else begin
                dvdQ    <= aMag;
                dvsQ    <= bMag;
                remQ    <= '0;
                countQ  <= '0;
                negQuoQ <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                negRemQ <= bus.signed_div & bus.a[WIDTH-1];
            end
        end else if ((stateQ == BUSY) && !bus.annul) begin
            dvdQ   <= quoNext;
            remQ   <= remNext;
            countQ <= countQ + CNT_W'(1);
            if (lastStep) begin
                resultQ <= {remFinal, quoFinal};
            end
        end
    end
endmodule

// File: tb/tb_mips_div.sv
// Self-checking bench for mips_div: fixed vectors, randomized operands against
// a plain-arithmetic model, and hand sequences for annul, stall_all and reset.
module tb_mips_div;
    localparam int unsigned W = 32;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    mips_div_if #(.WIDTH(W)) bus ();

    mips_div #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference: MIPS DIV/DIVU semantics via host arithmetic (truncating division)
    function automatic logic [63:0] refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one divide, scramble operands while it runs, and check latency/stall/result
    task automatic runOp(input bit sgn, input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] exp, input string nm);
        int cyc;
        int lat;
        bit seen;
        bit stallOk;
        lat = (bv == 32'd0) ? 1 : 33;
        @(negedge clk);
        bus.start = 1'b1;
        bus.signed_div = sgn;
        bus.a = av;
        bus.b = bv;
        #1;
        check({nm, " stall_c0"}, 64'(bus.div_stall), 64'd1);
        cyc = 0;
        seen = 1'b0;
        stallOk = 1'b1;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus.a = $urandom;
            bus.b = $urandom;
            bus.signed_div = 1'($urandom);
            #1;
            if (bus.ready === 1'b1) seen = 1'b1;
            else if (bus.div_stall !== 1'b1) stallOk = 1'b0;
        end
        check({nm, " latency"}, 64'(cyc), 64'(lat));
        check({nm, " stall_busy"}, 64'(stallOk), 64'd1);
        check({nm, " result"}, bus.result, exp);
        check({nm, " stall_done"}, 64'(bus.div_stall), 64'd0);
        bus.start = 1'b0;
        @(negedge clk);
        #1;
        check({nm, " idle_ready"}, 64'(bus.ready), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [63:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;
        bit          earlyReady;

        total = 0;
        bad = 0;
        vecs[0] = '{1'b0, 32'd7,          32'd2,          {32'h1,          32'h3}};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD}};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h1,          32'hFFFF_FFFD}};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0,          32'h8000_0000}};
        vecs[4] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000,  32'h0}};
        vecs[5] = '{1'b1, 32'h1234,       32'd0,          {32'h1234,       32'hFFFF_FFFF}};

        resetn = 1'b0;
        bus.start = 1'b1;
        bus.signed_div = 1'b0;
        bus.a = 32'd5;
        bus.b = 32'd3;
        bus.annul = 1'b0;
        bus.stall_all = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset ready", 64'(bus.ready), 64'd0);
        check("reset result", bus.result, 64'd0);
        check("reset stall", 64'(bus.div_stall), 64'd0);
        bus.start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            runOp(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i % 6 == 5) rb = 32'hFFFF_FFFF;
            runOp(rs, ra, rb, refDiv(rs, ra, rb), $sformatf("rnd%0d", i));
        end

        // stall_all high for cycles 20..39: DONE holds from 33 through 40, IDLE at 41
        @(negedge clk);
        bus.start = 1'b1;
        bus.signed_div = 1'b0;
        bus.a = 32'd1000;
        bus.b = 32'd7;
        earlyReady = 1'b0;
        for (int cyc = 1; cyc <= 41; cyc++) begin
            @(negedge clk);
            bus.stall_all = (cyc >= 20 && cyc <= 39);
            bus.start = (cyc <= 40);
            #1;
            if (cyc < 33 && bus.ready !== 1'b0) earlyReady = 1'b1;
            if (cyc == 33) check("stall result", bus.result, {32'd6, 32'd142});
            if (cyc == 33 || cyc == 36 || cyc == 40) begin
                check($sformatf("stall ready_c%0d", cyc), 64'(bus.ready), 64'd1);
                check($sformatf("stall divstall_c%0d", cyc), 64'(bus.div_stall), 64'd0);
            end
            if (cyc == 41) begin
                check("stall idle_ready", 64'(bus.ready), 64'd0);
                check("stall idle_div_stall", 64'(bus.div_stall), 64'd0);
            end
        end
        check("stall early_ready", 64'(earlyReady), 64'd0);
        bus.stall_all = 1'b0;

        // annul in BUSY cycle 10: IDLE at 11, ready never rises, result keeps old value
        held = bus.result;
        @(negedge clk);
        bus.start = 1'b1;
        bus.signed_div = 1'b1;
        bus.a = 32'hFFFF_0000;
        bus.b = 32'd3;
        earlyReady = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            bus.annul = (cyc == 10);
            if (cyc == 10) bus.start = 1'b0;
            #1;
            if (bus.ready !== 1'b0) earlyReady = 1'b1;
            if (cyc == 11) check("annul idle", 64'(bus.div_stall), 64'd0);
        end
        check("annul no_ready", 64'(earlyReady), 64'd0);
        check("annul result_held", bus.result, held);
        runOp(1'b1, 32'hFFFF_0000, 32'd3, refDiv(1'b1, 32'hFFFF_0000, 32'd3), "after_annul");

        // reset pulse mid-BUSY clears everything
        @(negedge clk);
        bus.start = 1'b1;
        bus.signed_div = 1'b0;
        bus.a = 32'd99;
        bus.b = 32'd4;
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_mid ready", 64'(bus.ready), 64'd0);
        check("rst_mid result", bus.result, 64'd0);
        check("rst_mid stall", 64'(bus.div_stall), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        resetn = 1'b1;
        runOp(1'b0, 32'd99, 32'd4, {32'd3, 32'd24}, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
